// File: rtl/shift_pkg.sv
// Shared definitions for the iterated shifter: opcode encoding, FSM state
// encoding and the default datapath width.
package shift_pkg;

    localparam int SHIFT_WIDTH = 8;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : shift_pkg

// File: rtl/shifter.sv
// Combinational shifter: logical shifts fill with zero, rotates wrap around.
module shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0] original,
    input  logic [2:0]       amount,
    input  logic [1:0]       opcode,
    output logic [WIDTH-1:0] result
);

    // Rotates are taken from a doubled copy of the operand so no amount-
    // dependent subtraction is needed.
    logic [2*WIDTH-1:0] w_dbl_left;
    logic [2*WIDTH-1:0] w_dbl_right;

    assign w_dbl_left  = {original, original} << amount;
    assign w_dbl_right = {original, original} >> amount;

    // Select the operation.
    always_comb begin
        result = original;
        case (opcode)
            OP_SLL:  result = original << amount;
            OP_SRL:  result = original >> amount;
            OP_ROL:  result = w_dbl_left[2*WIDTH-1:WIDTH];
            OP_ROR:  result = w_dbl_right[WIDTH-1:0];
            default: result = original;
        endcase
    end

endmodule : shifter

// File: rtl/shift_iterator.sv
// Sequential wrapper that applies the shifter repeatedly to a latched operand
// and presents the final value with a one-cycle done strobe.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; result holds the last completed value
//   ST_EXEC | one shifter pass per clock, cnt counts remaining passes
//   ST_DONE | done strobe for one cycle; start here is accepted directly
module shift_iterator
    import shift_pkg::*;
#(
    parameter int WIDTH  = SHIFT_WIDTH,
    parameter int REPS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  original,
    input  logic [2:0]        amount,
    input  logic [1:0]        opcode,
    input  logic [REPS_W-1:0] reps,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last_pass;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_shift;
    logic [2:0]         r_amt;
    logic [1:0]         r_op;
    logic [REPS_W-1:0]  r_cnt;

    shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .original(r_acc),
        .amount  (r_amt),
        .opcode  (r_op),
        .result  (w_shift)
    );

    assign w_last_pass = (r_cnt == REPS_W'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and command acceptance; DONE accepts like IDLE so commands
    // can run back to back.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (reps != '0) ? ST_EXEC : ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (w_last_pass) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch the command, iterate the accumulator, and capture the
    // result on the edge that enters DONE. A zero-repeat command enters DONE
    // straight from acceptance, so the operand itself is the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_amt    <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc <= original;
            r_amt <= amount;
            r_op  <= opcode;
            r_cnt <= reps;
            if (reps == '0) begin
                r_result <= original;
            end
        end else if (r_state == ST_EXEC) begin
            r_acc <= w_shift;
            r_cnt <= r_cnt - REPS_W'(1);
            if (w_last_pass) begin
                r_result <= w_shift;
            end
        end
    end

    assign busy   = (r_state == ST_EXEC);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule : shift_iterator

// File: tb/tb_shift_iterator.sv
module tb_shift_iterator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] original = '0;
    logic [2:0] amount = '0;
    logic [1:0] opcode = '0;
    logic [3:0] reps = '0;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    shift_iterator #(.WIDTH(8), .REPS_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .original(original),
        .amount(amount), .opcode(opcode), .reps(reps),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input int v, input int a, input int op, input int n);
        int x;
        x = v;
        repeat (n) begin
            case (op)
                0: x = (x << a) % 256;
                1: x = x >> a;
                2: x = ((x << a) | (x >> (8 - a))) % 256;
                default: x = ((x >> a) | (x << (8 - a))) % 256;
            endcase
        end
        return x[7:0];
    endfunction

    task automatic chk(input int obs, input int exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold start across one edge; scramble the inputs
    // afterwards so anything sampled late would show up as a wrong result.
    task automatic issue(input logic [7:0] o, input int a, input int op, input int r);
        original = o;
        amount   = 3'(a);
        opcode   = 2'(op);
        reps     = 4'(r);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        original = 8'($urandom);
        amount   = 3'($urandom);
        opcode   = 2'($urandom);
        reps     = 4'($urandom);
    endtask

    // Called one cycle after acceptance; follows the run to its done strobe.
    task automatic wait_done(input logic [7:0] exp, input int r, input bit noise, input string tag);
        int cycles;
        cycles = 1;
        while (!done && cycles <= 20) begin
            chk(busy, 1, {tag, "_busy"});
            if (noise) begin
                start    = 1'($urandom);
                original = 8'($urandom);
                amount   = 3'($urandom);
                opcode   = 2'($urandom);
                reps     = 4'($urandom);
            end
            tick();
            start = 1'b0;
            cycles++;
        end
        chk(done, 1, {tag, "_done_seen"});
        chk(cycles, r + 1, {tag, "_latency"});
        chk(busy, 0, {tag, "_busy_in_done"});
        chk(result, exp, {tag, "_result"});
    endtask

    task automatic settle(input logic [7:0] exp, input string tag);
        tick();
        chk(done, 0, {tag, "_done_one_cycle"});
        chk(busy, 0, {tag, "_idle_busy"});
        chk(result, exp, {tag, "_result_held"});
    endtask

    task automatic run(input logic [7:0] o, input int a, input int op, input int r,
                       input bit noise, input string tag);
        logic [7:0] exp;
        exp = model(o, a, op, r);
        issue(o, a, op, r);
        wait_done(exp, r, noise, tag);
    endtask

    initial begin
        logic [7:0] o, exp_a, exp_b;
        int a, op, r;

        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk(busy, 0, "por_busy");
        chk(done, 0, "por_done");
        chk(result, 0, "por_result");

        // Basic SLL run, fixed values.
        run(8'h01, 1, 0, 3, 1'b0, "sll3");
        chk(result, 8'h08, "sll3_const");
        settle(8'h08, "sll3");

        // Full rotation returns the operand.
        run(8'h8E, 1, 3, 8, 1'b0, "ror8");
        chk(result, 8'h8E, "ror8_const");
        settle(8'h8E, "ror8");

        // Zero repeats: done next cycle, busy never asserted.
        issue(8'hA5, 2, 2, 0);
        chk(busy, 0, "reps0_no_busy");
        wait_done(8'hA5, 0, 1'b0, "reps0");
        settle(8'hA5, "reps0");

        run(8'h80, 7, 1, 2, 1'b0, "srl7");
        chk(result, 8'h00, "srl7_const");
        settle(8'h00, "srl7");

        // Mid-simulation asynchronous reset, observed before any edge.
        run(8'h3C, 2, 2, 1, 1'b0, "pre_rst");
        reset = 1'b1;
        #1;
        chk(busy, 0, "arst_busy");
        chk(done, 0, "arst_done");
        chk(result, 0, "arst_result");
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Start pulses and operand changes while busy are ignored.
        run(8'h5B, 3, 2, 6, 1'b1, "noise");
        settle(model(8'h5B, 3, 2, 6), "noise");

        // Back-to-back: start held in DONE is taken with no IDLE cycle.
        exp_a = model(8'hC3, 1, 0, 4);
        exp_b = model(8'h96, 5, 3, 3);
        issue(8'hC3, 1, 0, 4);
        wait_done(exp_a, 4, 1'b0, "b2b_a");
        issue(8'h96, 5, 3, 3);
        chk(busy, 1, "b2b_no_idle");
        wait_done(exp_b, 3, 1'b0, "b2b_b");
        settle(exp_b, "b2b_b");

        // Reset while in EXEC with two passes left: abort, no done.
        issue(8'h71, 1, 2, 5);
        tick();
        tick();
        tick();
        chk(busy, 1, "abort_still_busy");
        reset = 1'b1;
        #1;
        chk(busy, 0, "abort_busy");
        chk(done, 0, "abort_done");
        chk(result, 0, "abort_result");
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk(done, 0, "abort_no_done");
            chk(result, 0, "abort_result_held");
        end
        run(8'h71, 1, 2, 5, 1'b0, "post_abort");
        settle(model(8'h71, 1, 2, 5), "post_abort");

        // Randomized commands, sometimes chained back to back.
        for (int k = 0; k < 30; k++) begin
            o  = 8'($urandom);
            a  = int'($urandom_range(0, 7));
            op = int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 15));
            run(o, a, op, r, 1'($urandom), "rand");
            if ($urandom_range(0, 1) == 0) begin
                settle(model(o, a, op, r), "rand");
            end
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_iterator
